// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight writes per architectural register
// and stalls issue on read-after-write hazards or counter saturation.
module reg_scoreboard #(
   parameter int NREG = 16,
   parameter int CW   = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            issue_valid,
   input  logic            issue_wb_en,
   input  logic [3:0]      issue_dest,
   input  logic [3:0]      rn,
   input  logic [3:0]      rdm,
   input  logic            two_src,
   input  logic            freeze,
   input  logic            flush,
   input  logic            wb_valid,
   input  logic [3:0]      wb_dest,
   output logic            hazard,
   output logic            issue_ok,
   output logic [NREG-1:0] pending,
   output logic            busy,
   output logic            err
);

   localparam logic [CW-1:0] CMAX = {CW{1'b1}};

   logic [CW-1:0]   cnt [NREG];
   logic [NREG-1:0] inc_vec;
   logic [NREG-1:0] dec_vec;
   logic            wb_same;
   logic            sat;
   logic            raw;
   logic            underflow;

   // Counters hold at their limits so they can never wrap.
   function automatic logic [CW-1:0] inc_sat(input logic [CW-1:0] c);
      return (c == CMAX) ? c : c + 1'b1;
   endfunction

   function automatic logic [CW-1:0] dec_sat(input logic [CW-1:0] c);
      return (c == '0) ? c : c - 1'b1;
   endfunction

   // Per-register pending flags and the aggregate busy flag.
   always_comb begin
      pending = '0;
      for (int i = 0; i < NREG; i++) begin
         pending[i] = (cnt[i] != '0);
      end
      busy = |pending;
   end

   // Hazard and accept decision; uses registered counts only, so a WB this
   // cycle releases a stall one cycle later. A same-cycle WB to the
   // destination does relieve saturation because the count will not grow.
   always_comb begin
      wb_same   = wb_valid && (wb_dest == issue_dest);
      sat       = issue_wb_en && (cnt[issue_dest] == CMAX) && !wb_same;
      raw       = pending[rn] || (two_src && pending[rdm]);
      hazard    = rst && issue_valid && (raw || sat);
      issue_ok  = rst && issue_valid && !hazard && !freeze && !flush;
      underflow = wb_valid && (cnt[wb_dest] == '0);
   end

   // Decode which counters move up (accepted issue) and down (retiring WB).
   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      for (int i = 0; i < NREG; i++) begin
         inc_vec[i] = issue_ok && issue_wb_en && (issue_dest == 4'(i));
         dec_vec[i] = wb_valid && (wb_dest == 4'(i));
      end
   end

   // Counter and sticky error state; an increment and decrement of the same
   // register in one cycle cancel out.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            cnt[i] <= '0;
         end
         err <= 1'b0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (inc_vec[i] && !dec_vec[i]) begin
               cnt[i] <= inc_sat(cnt[i]);
            end else if (dec_vec[i] && !inc_vec[i]) begin
               cnt[i] <= dec_sat(cnt[i]);
            end
         end
         if (underflow) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scenario bench for reg_scoreboard: each row drives one cycle of inputs
// and queues the outputs expected in that cycle.
module tb_reg_scoreboard;

   logic        clk;
   logic        rst;
   logic        issue_valid;
   logic        issue_wb_en;
   logic [3:0]  issue_dest;
   logic [3:0]  rn;
   logic [3:0]  rdm;
   logic        two_src;
   logic        freeze;
   logic        flush;
   logic        wb_valid;
   logic [3:0]  wb_dest;
   logic        hazard;
   logic        issue_ok;
   logic [15:0] pending;
   logic        busy;
   logic        err;

   int n_cmp;
   int n_bad;

   typedef struct {
      string       nm;
      logic        v;
      logic        wbe;
      logic [3:0]  dest;
      logic [3:0]  rn;
      logic [3:0]  rdm;
      logic        two;
      logic        frz;
      logic        fl;
      logic        wbv;
      logic [3:0]  wbd;
      logic        hz;
      logic        ok;
      logic [15:0] pend;
      logic        er;
   } stim_t;

   stim_t exp_q[$];

   reg_scoreboard #(.NREG(16), .CW(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .issue_valid (issue_valid),
      .issue_wb_en (issue_wb_en),
      .issue_dest  (issue_dest),
      .rn          (rn),
      .rdm         (rdm),
      .two_src     (two_src),
      .freeze      (freeze),
      .flush       (flush),
      .wb_valid    (wb_valid),
      .wb_dest     (wb_dest),
      .hazard      (hazard),
      .issue_ok    (issue_ok),
      .pending     (pending),
      .busy        (busy),
      .err         (err)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic stim_t mk(input string nm, input logic v, input logic wbe,
                                input logic [3:0] dest, input logic [3:0] rn_i,
                                input logic [3:0] rdm_i, input logic two,
                                input logic frz, input logic fl, input logic wbv,
                                input logic [3:0] wbd, input logic hz,
                                input logic ok, input logic [15:0] pend,
                                input logic er);
      stim_t s;
      s.nm = nm; s.v = v; s.wbe = wbe; s.dest = dest; s.rn = rn_i; s.rdm = rdm_i;
      s.two = two; s.frz = frz; s.fl = fl; s.wbv = wbv; s.wbd = wbd;
      s.hz = hz; s.ok = ok; s.pend = pend; s.er = er;
      return s;
   endfunction

   task automatic drive(input stim_t s);
      issue_valid = s.v;
      issue_wb_en = s.wbe;
      issue_dest  = s.dest;
      rn          = s.rn;
      rdm         = s.rdm;
      two_src     = s.two;
      freeze      = s.frz;
      flush       = s.fl;
      wb_valid    = s.wbv;
      wb_dest     = s.wbd;
      exp_q.push_back(s);
   endtask

   task automatic test_reset();
      stim_t rows[$];
      stim_t e;
      rows.push_back(mk("rst_issue",  1,1,4'd3,4'd3,4'd3,1,0,0,0,4'd0, 0,0,16'h0000,0));
      rows.push_back(mk("rst_wb",     1,1,4'd3,4'd0,4'd0,0,0,0,1,4'd3, 0,0,16'h0000,0));
      rows.push_back(mk("post_rst",   0,0,4'd0,4'd0,4'd0,0,0,0,0,4'd0, 0,0,16'h0000,0));
      foreach (rows[k]) begin
         if (k == 2) rst = 1'b1;
         drive(rows[k]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_cmp++;
         if ({hazard, issue_ok, busy, err, pending} !== {e.hz, e.ok, (|e.pend), e.er, e.pend}) begin
            n_bad++;
            $display("FAIL %s: got hz=%b ok=%b busy=%b err=%b pend=%h, want hz=%b ok=%b busy=%b err=%b pend=%h",
                     e.nm, hazard, issue_ok, busy, err, pending, e.hz, e.ok, (|e.pend), e.er, e.pend);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_raw();
      stim_t rows[$];
      stim_t e;
      rows.push_back(mk("raw_issue",   1,1,4'd3,4'd0,4'd0,0,0,0,0,4'd0, 0,1,16'h0000,0));
      rows.push_back(mk("raw_stall",   1,0,4'd0,4'd3,4'd0,0,0,0,0,4'd0, 1,0,16'h0008,0));
      rows.push_back(mk("raw_wb_same", 1,0,4'd0,4'd3,4'd0,0,0,0,1,4'd3, 1,0,16'h0008,0));
      rows.push_back(mk("raw_release", 1,0,4'd0,4'd3,4'd0,0,0,0,0,4'd0, 0,1,16'h0000,0));
      foreach (rows[k]) begin
         drive(rows[k]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_cmp++;
         if ({hazard, issue_ok, busy, err, pending} !== {e.hz, e.ok, (|e.pend), e.er, e.pend}) begin
            n_bad++;
            $display("FAIL %s: got hz=%b ok=%b busy=%b err=%b pend=%h, want hz=%b ok=%b busy=%b err=%b pend=%h",
                     e.nm, hazard, issue_ok, busy, err, pending, e.hz, e.ok, (|e.pend), e.er, e.pend);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_saturation();
      stim_t rows[$];
      stim_t e;
      rows.push_back(mk("sat_i1",       1,1,4'd5,4'd0,4'd0,0,0,0,0,4'd0, 0,1,16'h0000,0));
      rows.push_back(mk("sat_i2",       1,1,4'd5,4'd0,4'd0,0,0,0,0,4'd0, 0,1,16'h0020,0));
      rows.push_back(mk("sat_i3",       1,1,4'd5,4'd0,4'd0,0,0,0,0,4'd0, 0,1,16'h0020,0));
      rows.push_back(mk("sat_stall",    1,1,4'd5,4'd0,4'd0,0,0,0,0,4'd0, 1,0,16'h0020,0));
      rows.push_back(mk("sat_wb_issue", 1,1,4'd5,4'd0,4'd0,0,0,0,1,4'd5, 0,1,16'h0020,0));
      rows.push_back(mk("sat_still3",   1,1,4'd5,4'd0,4'd0,0,0,0,0,4'd0, 1,0,16'h0020,0));
      rows.push_back(mk("sat_drain1",   0,0,4'd0,4'd0,4'd0,0,0,0,1,4'd5, 0,0,16'h0020,0));
      rows.push_back(mk("sat_drain2",   0,0,4'd0,4'd0,4'd0,0,0,0,1,4'd5, 0,0,16'h0020,0));
      rows.push_back(mk("sat_drain3",   0,0,4'd0,4'd0,4'd0,0,0,0,1,4'd5, 0,0,16'h0020,0));
      rows.push_back(mk("sat_empty",    0,0,4'd0,4'd0,4'd0,0,0,0,0,4'd0, 0,0,16'h0000,0));
      foreach (rows[k]) begin
         drive(rows[k]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_cmp++;
         if ({hazard, issue_ok, busy, err, pending} !== {e.hz, e.ok, (|e.pend), e.er, e.pend}) begin
            n_bad++;
            $display("FAIL %s: got hz=%b ok=%b busy=%b err=%b pend=%h, want hz=%b ok=%b busy=%b err=%b pend=%h",
                     e.nm, hazard, issue_ok, busy, err, pending, e.hz, e.ok, (|e.pend), e.er, e.pend);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_freeze_flush();
      stim_t rows[$];
      stim_t e;
      rows.push_back(mk("frz_issue7",  1,1,4'd7,4'd0,4'd0,0,0,0,0,4'd0, 0,1,16'h0000,0));
      rows.push_back(mk("frz_block",   1,1,4'd2,4'd0,4'd0,0,1,0,1,4'd7, 0,0,16'h0080,0));
      rows.push_back(mk("frz_after",   0,0,4'd0,4'd0,4'd0,0,0,0,0,4'd0, 0,0,16'h0000,0));
      rows.push_back(mk("flush_block", 1,1,4'd2,4'd0,4'd0,0,0,1,0,4'd0, 0,0,16'h0000,0));
      rows.push_back(mk("flush_after", 0,0,4'd0,4'd0,4'd0,0,0,0,0,4'd0, 0,0,16'h0000,0));
      foreach (rows[k]) begin
         drive(rows[k]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_cmp++;
         if ({hazard, issue_ok, busy, err, pending} !== {e.hz, e.ok, (|e.pend), e.er, e.pend}) begin
            n_bad++;
            $display("FAIL %s: got hz=%b ok=%b busy=%b err=%b pend=%h, want hz=%b ok=%b busy=%b err=%b pend=%h",
                     e.nm, hazard, issue_ok, busy, err, pending, e.hz, e.ok, (|e.pend), e.er, e.pend);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_two_src();
      stim_t rows[$];
      stim_t e;
      rows.push_back(mk("ts_issue4", 1,1,4'd4,4'd0,4'd0,0,0,0,0,4'd0, 0,1,16'h0000,0));
      rows.push_back(mk("ts_one",    1,0,4'd0,4'd0,4'd4,0,0,0,0,4'd0, 0,1,16'h0010,0));
      rows.push_back(mk("ts_two",    1,0,4'd0,4'd0,4'd4,1,0,0,0,4'd0, 1,0,16'h0010,0));
      rows.push_back(mk("ts_wb",     0,0,4'd0,4'd0,4'd0,0,0,0,1,4'd4, 0,0,16'h0010,0));
      rows.push_back(mk("ts_clear",  0,0,4'd0,4'd0,4'd0,0,0,0,0,4'd0, 0,0,16'h0000,0));
      foreach (rows[k]) begin
         drive(rows[k]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_cmp++;
         if ({hazard, issue_ok, busy, err, pending} !== {e.hz, e.ok, (|e.pend), e.er, e.pend}) begin
            n_bad++;
            $display("FAIL %s: got hz=%b ok=%b busy=%b err=%b pend=%h, want hz=%b ok=%b busy=%b err=%b pend=%h",
                     e.nm, hazard, issue_ok, busy, err, pending, e.hz, e.ok, (|e.pend), e.er, e.pend);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      stim_t rows[$];
      stim_t e;
      rows.push_back(mk("bb_issue6",   1,1,4'd6,4'd0,4'd0,0,0,0,0,4'd0, 0,1,16'h0000,0));
      rows.push_back(mk("bb_self8",    1,1,4'd8,4'd8,4'd0,0,0,0,1,4'd6, 0,1,16'h0040,0));
      rows.push_back(mk("bb_check",    0,0,4'd0,4'd0,4'd0,0,0,0,0,4'd0, 0,0,16'h0100,0));
      rows.push_back(mk("bb_incdec8",  1,1,4'd8,4'd0,4'd0,0,0,0,1,4'd8, 0,1,16'h0100,0));
      rows.push_back(mk("bb_wb8",      0,0,4'd0,4'd0,4'd0,0,0,0,1,4'd8, 0,0,16'h0100,0));
      rows.push_back(mk("bb_done",     0,0,4'd0,4'd0,4'd0,0,0,0,0,4'd0, 0,0,16'h0000,0));
      foreach (rows[k]) begin
         drive(rows[k]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_cmp++;
         if ({hazard, issue_ok, busy, err, pending} !== {e.hz, e.ok, (|e.pend), e.er, e.pend}) begin
            n_bad++;
            $display("FAIL %s: got hz=%b ok=%b busy=%b err=%b pend=%h, want hz=%b ok=%b busy=%b err=%b pend=%h",
                     e.nm, hazard, issue_ok, busy, err, pending, e.hz, e.ok, (|e.pend), e.er, e.pend);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_err();
      stim_t rows[$];
      stim_t tail[$];
      stim_t e;
      rows.push_back(mk("err_wb9",     0,0,4'd0,4'd0,4'd0,0,0,0,1,4'd9, 0,0,16'h0000,0));
      rows.push_back(mk("err_set",     0,0,4'd0,4'd0,4'd0,0,0,0,0,4'd0, 0,0,16'h0000,1));
      rows.push_back(mk("err_sticky",  1,1,4'd1,4'd0,4'd0,0,0,0,0,4'd0, 0,1,16'h0000,1));
      rows.push_back(mk("err_pend1",   0,0,4'd0,4'd0,4'd0,0,0,0,0,4'd0, 0,0,16'h0002,1));
      foreach (rows[k]) begin
         drive(rows[k]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_cmp++;
         if ({hazard, issue_ok, busy, err, pending} !== {e.hz, e.ok, (|e.pend), e.er, e.pend}) begin
            n_bad++;
            $display("FAIL %s: got hz=%b ok=%b busy=%b err=%b pend=%h, want hz=%b ok=%b busy=%b err=%b pend=%h",
                     e.nm, hazard, issue_ok, busy, err, pending, e.hz, e.ok, (|e.pend), e.er, e.pend);
         end
         @(posedge clk); #1;
      end
      // Mid-cycle asynchronous reset while R1 is pending and a reader of R1 is presented.
      drive(mk("async_rst", 1,1,4'd2,4'd1,4'd0,0,0,0,0,4'd0, 0,0,16'h0000,0));
      #2 rst = 1'b0;
      #1;
      e = exp_q.pop_front();
      n_cmp++;
      if ({hazard, issue_ok, busy, err, pending} !== {e.hz, e.ok, (|e.pend), e.er, e.pend}) begin
         n_bad++;
         $display("FAIL %s: got hz=%b ok=%b busy=%b err=%b pend=%h, want hz=%b ok=%b busy=%b err=%b pend=%h",
                  e.nm, hazard, issue_ok, busy, err, pending, e.hz, e.ok, (|e.pend), e.er, e.pend);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      // The write to R1 was discarded by reset, so its late WB is an underflow.
      tail.push_back(mk("lost_wb1",   0,0,4'd0,4'd0,4'd0,0,0,0,1,4'd1, 0,0,16'h0000,0));
      tail.push_back(mk("lost_err",   0,0,4'd0,4'd0,4'd0,0,0,0,0,4'd0, 0,0,16'h0000,1));
      foreach (tail[k]) begin
         drive(tail[k]);
         @(negedge clk);
         e = exp_q.pop_front();
         n_cmp++;
         if ({hazard, issue_ok, busy, err, pending} !== {e.hz, e.ok, (|e.pend), e.er, e.pend}) begin
            n_bad++;
            $display("FAIL %s: got hz=%b ok=%b busy=%b err=%b pend=%h, want hz=%b ok=%b busy=%b err=%b pend=%h",
                     e.nm, hazard, issue_ok, busy, err, pending, e.hz, e.ok, (|e.pend), e.er, e.pend);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      clk         = 1'b0;
      rst         = 1'b0;
      issue_valid = 1'b0;
      issue_wb_en = 1'b0;
      issue_dest  = 4'd0;
      rn          = 4'd0;
      rdm         = 4'd0;
      two_src     = 1'b0;
      freeze      = 1'b0;
      flush       = 1'b0;
      wb_valid    = 1'b0;
      wb_dest     = 4'd0;
      n_cmp       = 0;
      n_bad       = 0;
      @(posedge clk); #1;
      test_reset();
      test_raw();
      test_saturation();
      test_freeze_flush();
      test_two_src();
      test_back_to_back();
      test_err();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
